ram_access_arbiter: RTL and testbench

Two-requester arbiter that shares the 4096 x 64 dual-port RAM (`ram_4096`) between two write clients and two read clients. Write and read ports are arbitrated independently, each with a round-robin pointer. The block steers address, data and strobes onto the RAM and returns tagged read data one cycle after grant. Same-cycle read/write collisions to the same address are forwarded so the reader always sees the new data. The block sits directly in front of `ram_4096`; all RAM traffic passes through it.

---
 rtl/ram_access_arbiter_if.sv | 41 ++++
 rtl/ram_access_arbiter.sv | 112 +++++++++++
 tb/tb_ram_access_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// Bundle of client-side and RAM-side signals around ram_access_arbiter.
//   wr0/wr1 : write request, address, data in; grant out
//   rd0/rd1 : read request, address in; grant, rvalid, rdata out
//   ram_*   : strobes, addresses and data to/from the dual-port RAM
// slave modport is the arbiter's view; master is the clients' and RAM's view.
interface ram_access_arbiter_if #(
    parameter int unsigned RAM_WIDTH = 64,
    parameter int unsigned ADDR_SIZE = 12
);
    logic                 wr0_req,    wr1_req;
    logic [ADDR_SIZE-1:0] wr0_addr,   wr1_addr;
    logic [RAM_WIDTH-1:0] wr0_data,   wr1_data;
    logic                 wr0_gnt,    wr1_gnt;
    logic                 rd0_req,    rd1_req;
    logic [ADDR_SIZE-1:0] rd0_addr,   rd1_addr;
    logic                 rd0_gnt,    rd1_gnt;
    logic                 rd0_rvalid, rd1_rvalid;
    logic [RAM_WIDTH-1:0] rd0_rdata,  rd1_rdata;
    logic                 ram_write;
    logic [ADDR_SIZE-1:0] ram_wr_address;
    logic [RAM_WIDTH-1:0] ram_data_in;
    logic                 ram_read;
    logic [ADDR_SIZE-1:0] ram_rd_address;
    logic [RAM_WIDTH-1:0] ram_data_out;

    modport slave (
        input  wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        input  rd0_req, rd1_req, rd0_addr, rd1_addr, ram_data_out,
        output wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt,
        output rd0_rvalid, rd1_rvalid, rd0_rdata, rd1_rdata,
        output ram_write, ram_wr_address, ram_data_in, ram_read, ram_rd_address
    );

    modport master (
        output wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        output rd0_req, rd1_req, rd0_addr, rd1_addr, ram_data_out,
        input  wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt,
        input  rd0_rvalid, rd1_rvalid, rd0_rdata, rd1_rdata,
        input  ram_write, ram_wr_address, ram_data_in, ram_read, ram_rd_address
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares a dual-port RAM between two write clients and two read clients.
// Write and read ports each have an independent 1-bit round-robin pointer.
// Read data returns one cycle after grant, tagged to the granted client; a
// same-cycle write to the read address is forwarded so the reader sees new data.
//   clk   : rising-edge clock (RAM and arbiter)
//   rst_n : asynchronous active-low reset
//   bus   : client request/grant/response signals and RAM strobes (slave view)
module ram_access_arbiter #(
    parameter int unsigned RAM_WIDTH = 64,
    parameter int unsigned ADDR_SIZE = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_arbiter_if.slave   bus
);
    logic wptr_q, wptr_d;
    logic rptr_q, rptr_d;

    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q,    rsp_id_d;
    logic                 byp_hit_q,   byp_hit_d;
    logic [RAM_WIDTH-1:0] byp_data_q,  byp_data_d;

    logic                 wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
    logic                 wr_any, rd_any;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic [RAM_WIDTH-1:0] wr_data, rsp_data;

    // Arbitration and steering: purely combinational from req and pointers.
    always_comb begin
        wr0_gnt = bus.wr0_req & (~bus.wr1_req | ~wptr_q);
        wr1_gnt = bus.wr1_req & (~bus.wr0_req |  wptr_q);
        rd0_gnt = bus.rd0_req & (~bus.rd1_req | ~rptr_q);
        rd1_gnt = bus.rd1_req & (~bus.rd0_req |  rptr_q);
        wr_any  = wr0_gnt | wr1_gnt;
        rd_any  = rd0_gnt | rd1_gnt;

        wr_addr = '0;
        wr_data = '0;
        if (wr0_gnt) begin
            wr_addr = bus.wr0_addr;
            wr_data = bus.wr0_data;
        end else if (wr1_gnt) begin
            wr_addr = bus.wr1_addr;
            wr_data = bus.wr1_data;
        end

        rd_addr = '0;
        if (rd0_gnt) begin
            rd_addr = bus.rd0_addr;
        end else if (rd1_gnt) begin
            rd_addr = bus.rd1_addr;
        end
    end

    // Next state: pointer hands priority to the client that lost (or was idle).
    always_comb begin
        wptr_d = wptr_q;
        if (wr0_gnt) begin
            wptr_d = 1'b1;
        end else if (wr1_gnt) begin
            wptr_d = 1'b0;
        end

        rptr_d = rptr_q;
        if (rd0_gnt) begin
            rptr_d = 1'b1;
        end else if (rd1_gnt) begin
            rptr_d = 1'b0;
        end

        rsp_valid_d = rd_any;
        rsp_id_d    = rd1_gnt;
        // RAM returns the old word on a same-address collision, so keep the new one.
        byp_hit_d   = rd_any & wr_any & (rd_addr == wr_addr);
        byp_data_d  = byp_hit_d ? wr_data : byp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            byp_hit_q   <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            byp_hit_q   <= byp_hit_d;
            byp_data_q  <= byp_data_d;
        end
    end

    assign rsp_data = byp_hit_q ? byp_data_q : bus.ram_data_out;

    assign bus.wr0_gnt        = wr0_gnt;
    assign bus.wr1_gnt        = wr1_gnt;
    assign bus.rd0_gnt        = rd0_gnt;
    assign bus.rd1_gnt        = rd1_gnt;
    assign bus.ram_write      = wr_any;
    assign bus.ram_wr_address = wr_addr;
    assign bus.ram_data_in    = wr_data;
    assign bus.ram_read       = rd_any;
    assign bus.ram_rd_address = rd_addr;
    assign bus.rd0_rvalid     = rsp_valid_q & ~rsp_id_q;
    assign bus.rd1_rvalid     = rsp_valid_q &  rsp_id_q;
    assign bus.rd0_rdata      = (rsp_valid_q & ~rsp_id_q) ? rsp_data : '0;
    assign bus.rd1_rdata      = (rsp_valid_q &  rsp_id_q) ? rsp_data : '0;
endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ram_access_arbiter_if #(.RAM_WIDTH(64), .ADDR_SIZE(12)) bus ();

    ram_access_arbiter #(.RAM_WIDTH(64), .ADDR_SIZE(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural RAM: registered read returning the pre-write word on collision.
    logic [63:0] ram_mem [0:4095];
    always @(posedge clk) begin
        if (bus.ram_read)  bus.ram_data_out <= ram_mem[bus.ram_rd_address];
        if (bus.ram_write) ram_mem[bus.ram_wr_address] <= bus.ram_data_in;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr0_req = 0; bus.wr1_req = 0; bus.rd0_req = 0; bus.rd1_req = 0;
        bus.wr0_addr = '0; bus.wr1_addr = '0; bus.rd0_addr = '0; bus.rd1_addr = '0;
        bus.wr0_data = '0; bus.wr1_data = '0;
    endtask

    task automatic chk_no_rsp(input string tag);
        chk({tag, " rd0_rvalid"}, 64'(bus.rd0_rvalid), 64'd0);
        chk({tag, " rd1_rvalid"}, 64'(bus.rd1_rvalid), 64'd0);
        chk({tag, " rd0_rdata"}, bus.rd0_rdata, 64'd0);
        chk({tag, " rd1_rdata"}, bus.rd1_rdata, 64'd0);
    endtask

    // Round-robin reference: on contention the client not granted last time wins.
    function automatic int pick(input bit a, input bit b, input int last);
        if (a && b) return (last == 0) ? 1 : 0;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    typedef struct {
        logic [3:0] req;   // {wr0, wr1, rd0, rd1}
        logic [3:0] gnt;   // expected {wr0, wr1, rd0, rd1}
    } vec_t;
    vec_t tbl [9];

    logic [63:0] mdl [0:4095];
    bit          pw [2];
    bit          pr [2];
    logic [11:0] wa [2];
    logic [11:0] ra [2];
    logic [63:0] wd [2];

    initial begin
        int          lw, lr, gw, gr, eid, nid;
        bit          ev, nv;
        logic [63:0] edata, ndata, ew_data;
        logic [11:0] ew_addr, er_addr;

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            mdl[i]     = '0;
        end
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk_no_rsp("reset");
        #20 rst_n = 1'b1;
        tick();

        // Arbitration table, applied in order from reset (both pointers start at 0).
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b1111, 4'b1010};
        tbl[2] = '{4'b1111, 4'b0101};
        tbl[3] = '{4'b0101, 4'b0101};
        tbl[4] = '{4'b1111, 4'b1010};
        tbl[5] = '{4'b1010, 4'b1010};
        tbl[6] = '{4'b1111, 4'b0101};
        tbl[7] = '{4'b0000, 4'b0000};
        tbl[8] = '{4'b1111, 4'b1010};
        bus.wr0_addr = 12'h100; bus.wr1_addr = 12'h200;
        bus.rd0_addr = 12'h300; bus.rd1_addr = 12'h400;
        bus.wr0_data = 64'h1111; bus.wr1_data = 64'h2222;
        for (int i = 0; i < 9; i++) begin
            {bus.wr0_req, bus.wr1_req, bus.rd0_req, bus.rd1_req} = tbl[i].req;
            #3;
            chk($sformatf("tbl%0d gnt", i),
                64'({bus.wr0_gnt, bus.wr1_gnt, bus.rd0_gnt, bus.rd1_gnt}), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d ram_write", i), 64'(bus.ram_write),
                64'(tbl[i].gnt[3] | tbl[i].gnt[2]));
            chk($sformatf("tbl%0d ram_wr_address", i), 64'(bus.ram_wr_address),
                tbl[i].gnt[3] ? 64'h100 : (tbl[i].gnt[2] ? 64'h200 : 64'h0));
            chk($sformatf("tbl%0d ram_read", i), 64'(bus.ram_read),
                64'(tbl[i].gnt[1] | tbl[i].gnt[0]));
            chk($sformatf("tbl%0d ram_rd_address", i), 64'(bus.ram_rd_address),
                tbl[i].gnt[1] ? 64'h300 : (tbl[i].gnt[0] ? 64'h400 : 64'h0));
            tick();
        end
        idle_inputs();
        tick();

        // Write then read back through the other client.
        bus.wr0_req = 1; bus.wr0_addr = 12'h005; bus.wr0_data = 64'hDEAD_BEEF_0000_0001;
        #3 chk("wr0 gnt single", 64'(bus.wr0_gnt), 64'd1);
        tick();
        idle_inputs();
        bus.rd1_req = 1; bus.rd1_addr = 12'h005;
        #3 chk("rd1 gnt single", 64'(bus.rd1_gnt), 64'd1);
        tick();
        idle_inputs();
        #3;
        chk("rd1 rvalid", 64'(bus.rd1_rvalid), 64'd1);
        chk("rd1 rdata", bus.rd1_rdata, 64'hDEAD_BEEF_0000_0001);
        chk("rd0 rvalid idle", 64'(bus.rd0_rvalid), 64'd0);
        tick();

        // Same-address collision must forward the new write data.
        bus.wr1_req = 1; bus.wr1_addr = 12'h7FF; bus.wr1_data = 64'hAAAA;
        tick();
        bus.wr1_data = 64'h1234;
        bus.rd0_req = 1; bus.rd0_addr = 12'h7FF;
        tick();
        bus.wr1_req = 0;
        #3;
        chk("fwd rd0 rvalid", 64'(bus.rd0_rvalid), 64'd1);
        chk("fwd rd0 rdata", bus.rd0_rdata, 64'h1234);
        tick();
        idle_inputs();
        #3 chk("reread rd0 rdata", bus.rd0_rdata, 64'h1234);
        tick();

        // Reset pulsed the cycle after a grant drops the response and clears pointers.
        bus.rd0_req = 1; bus.rd0_addr = 12'h005;
        bus.wr0_req = 1; bus.wr0_addr = 12'h006; bus.wr0_data = 64'h66;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk_no_rsp("mid-reset");
        #2 rst_n = 1'b1;
        tick();
        bus.wr0_req = 1; bus.wr1_req = 1; bus.rd0_req = 1; bus.rd1_req = 1;
        #3;
        chk("post-reset gnt", 64'({bus.wr0_gnt, bus.wr1_gnt, bus.rd0_gnt, bus.rd1_gnt}),
            64'b1010);
        idle_inputs();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();

        // Randomised traffic against the reference model (addresses 0x0F0..0x0F7).
        lw = 1; lr = 1; ev = 0; eid = 0; edata = '0;
        pw = '{0, 0}; pr = '{0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pw[c] && $urandom_range(0, 3) != 0) begin
                    pw[c] = 1;
                    wa[c] = 12'h0F0 + 12'($urandom_range(0, 7));
                    wd[c] = {$urandom, $urandom};
                end
                if (!pr[c] && $urandom_range(0, 3) != 0) begin
                    pr[c] = 1;
                    ra[c] = 12'h0F0 + 12'($urandom_range(0, 7));
                end
            end
            bus.wr0_req = pw[0]; bus.wr0_addr = wa[0]; bus.wr0_data = wd[0];
            bus.wr1_req = pw[1]; bus.wr1_addr = wa[1]; bus.wr1_data = wd[1];
            bus.rd0_req = pr[0]; bus.rd0_addr = ra[0];
            bus.rd1_req = pr[1]; bus.rd1_addr = ra[1];
            gw = pick(pw[0], pw[1], lw);
            gr = pick(pr[0], pr[1], lr);
            ew_addr = (gw >= 0) ? wa[gw] : 12'h0;
            ew_data = (gw >= 0) ? wd[gw] : 64'h0;
            er_addr = (gr >= 0) ? ra[gr] : 12'h0;
            #3;
            chk("rnd rd0_rvalid", 64'(bus.rd0_rvalid), 64'(ev && eid == 0));
            chk("rnd rd1_rvalid", 64'(bus.rd1_rvalid), 64'(ev && eid == 1));
            chk("rnd rd0_rdata", bus.rd0_rdata, (ev && eid == 0) ? edata : 64'h0);
            chk("rnd rd1_rdata", bus.rd1_rdata, (ev && eid == 1) ? edata : 64'h0);
            chk("rnd wgnt", 64'({bus.wr0_gnt, bus.wr1_gnt}), 64'({gw == 0, gw == 1}));
            chk("rnd rgnt", 64'({bus.rd0_gnt, bus.rd1_gnt}), 64'({gr == 0, gr == 1}));
            chk("rnd ram_wr_address", 64'(bus.ram_wr_address), 64'(ew_addr));
            chk("rnd ram_data_in", bus.ram_data_in, ew_data);
            chk("rnd ram_rd_address", 64'(bus.ram_rd_address), 64'(er_addr));
            nv = 0; nid = 0; ndata = '0;
            if (gr >= 0) begin
                nv = 1;
                nid = gr;
                ndata = (gw >= 0 && wa[gw] == ra[gr]) ? wd[gw] : mdl[ra[gr]];
                pr[gr] = 0;
                lr = gr;
            end
            if (gw >= 0) begin
                mdl[wa[gw]] = wd[gw];
                pw[gw] = 0;
                lw = gw;
            end
            ev = nv; eid = nid; edata = ndata;
            tick();
        end

        // Idle bus.
        idle_inputs();
        tick();
        #3;
        chk("idle ram_write", 64'(bus.ram_write), 64'd0);
        chk("idle ram_read", 64'(bus.ram_read), 64'd0);
        chk("idle addrs/data", {40'd0, bus.ram_wr_address, bus.ram_rd_address},
            64'd0);
        chk("idle ram_data_in", bus.ram_data_in, 64'd0);
        chk_no_rsp("idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
